// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file and its hazard scoreboard.
// The pending vector is sized for the largest supported register count.
package regfile_scoreboard_pkg;

    localparam int REGS_MAX    = 32;
    localparam int REG_IDX_W   = 5;
    localparam int STALL_CNT_W = 16;

    typedef logic [REGS_MAX-1:0] pending_t;

    // Lowest bit of lane idx in a bus made of equal-width packed lanes
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-write scoreboard: tracks in-flight producers, raises RAW/WAW stalls
// and flags illegal writebacks and selects with a registered error pulse.
module reg_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_READ = 2,
    parameter int R0_ZERO  = 0,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ-1:0]       rd_en,
    input  logic [NUM_READ*SEL_W-1:0] rd_sel,
    input  logic                      iss_en,
    input  logic [SEL_W-1:0]          iss_sel,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    output logic [NUM_READ-1:0]       rd_busy,
    output logic                      stall,
    output logic                      iss_ack,
    output logic                      wr_commit,
    output logic                      err
);

    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W+1)'(NUM_REGS);

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return {1'b0, sel} < REG_LIMIT;
    endfunction

    function automatic logic is_r0(input logic [SEL_W-1:0] sel);
        return (R0_ZERO != 0) && (sel == '0);
    endfunction

    // Bits above NUM_REGS are never set, so out-of-range selects read as idle
    function automatic logic pend_at(input pending_t vec, input logic [SEL_W-1:0] sel);
        return vec[REG_IDX_W'(sel)];
    endfunction

    pending_t            pending_reg, pending_next;
    logic                err_reg, err_next;
    logic                wr_in_range, iss_in_range, iss_commit, waw;
    logic [NUM_READ-1:0] rd_bad;

    assign wr_in_range  = in_range(wr_sel);
    assign iss_in_range = in_range(iss_sel);
    assign wr_commit    = wr_en && wr_in_range && !is_r0(wr_sel);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_port
            logic [SEL_W-1:0] sel;
            assign sel         = rd_sel[slice_lo(gi, SEL_W) +: SEL_W];
            assign rd_busy[gi] = rd_en[gi] && pend_at(pending_reg, sel) && !(wr_en && wr_sel == sel);
            assign rd_bad[gi]  = rd_en[gi] && !in_range(sel);
        end
    endgenerate

    assign waw        = iss_en && pend_at(pending_reg, iss_sel) && !(wr_en && wr_sel == iss_sel);
    assign stall      = (|rd_busy) || waw;
    assign iss_ack    = iss_en && !stall;
    assign iss_commit = iss_ack && iss_in_range && !is_r0(iss_sel);

    // Set after clear: a same-cycle writeback and new issue leave the new producer pending
    always_comb begin
        pending_next = pending_reg;
        if (wr_commit) begin
            pending_next[REG_IDX_W'(wr_sel)] = 1'b0;
        end
        if (iss_commit) begin
            pending_next[REG_IDX_W'(iss_sel)] = 1'b1;
        end
        err_next = (wr_commit && !pend_at(pending_reg, wr_sel))
                || (wr_en && !wr_in_range)
                || (iss_en && !iss_in_range)
                || (|rd_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            err_reg     <= err_next;
        end
    end

    assign err = err_reg;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with write-to-read bypass, hazard
// scoreboard and saturating stall-cycle counter.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_READ = 2,
    parameter int R0_ZERO  = 0,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_READ-1:0]        rd_en,
    input  logic [NUM_READ*SEL_W-1:0]  rd_sel,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    output logic [NUM_READ-1:0]        rd_busy,
    input  logic                       iss_en,
    input  logic [SEL_W-1:0]           iss_sel,
    output logic                       iss_ack,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_sel,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       stall,
    output logic [STALL_CNT_W-1:0]     stall_cnt,
    output logic                       err
);

    localparam logic [SEL_W:0] REG_LIMIT = (SEL_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]      regs_reg [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic                   wr_commit;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ),
        .R0_ZERO  (R0_ZERO),
        .SEL_W    (SEL_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .iss_en    (iss_en),
        .iss_sel   (iss_sel),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .rd_busy   (rd_busy),
        .stall     (stall),
        .iss_ack   (iss_ack),
        .wr_commit (wr_commit),
        .err       (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_reg[wr_sel] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [SEL_W-1:0]  sel;
            logic [DATA_W-1:0] data;
            assign sel = rd_sel[slice_lo(gi, SEL_W) +: SEL_W];
            // Out-of-range and hardwired-zero selects read 0 and never take the bypass
            always_comb begin
                data = '0;
                if (({1'b0, sel} < REG_LIMIT) && !((R0_ZERO != 0) && sel == '0)) begin
                    if (wr_commit && wr_sel == sel) begin
                        data = wr_data;
                    end else begin
                        data = regs_reg[sel];
                    end
                end
            end
            assign rd_data[slice_lo(gi, DATA_W) +: DATA_W] = data;
        end
    endgenerate

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && stall_cnt_reg != '1) begin
            stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: vector table on the default configuration,
// plus hand sequences for out-of-range selects, R0_ZERO/wide config, saturation and async reset.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration: 16-bit, 8 regs, 2 ports
    logic [1:0]  a_rd_en = '0;
    logic [5:0]  a_rd_sel = '0;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_iss_en = 1'b0, a_iss_ack, a_wr_en = 1'b0, a_stall, a_err;
    logic [2:0]  a_iss_sel = '0, a_wr_sel = '0;
    logic [15:0] a_wr_data = '0, a_stall_cnt;

    regfile_scoreboard dut_a (
        .clk(clk), .rst(rst), .rd_en(a_rd_en), .rd_sel(a_rd_sel), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .iss_en(a_iss_en), .iss_sel(a_iss_sel), .iss_ack(a_iss_ack),
        .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_data(a_wr_data), .stall(a_stall),
        .stall_cnt(a_stall_cnt), .err(a_err)
    );

    // Six registers: selects 6 and 7 are out of range
    logic [1:0]  b_rd_en = '0;
    logic [5:0]  b_rd_sel = '0;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic        b_iss_en = 1'b0, b_iss_ack, b_wr_en = 1'b0, b_stall, b_err;
    logic [2:0]  b_iss_sel = '0, b_wr_sel = '0;
    logic [15:0] b_wr_data = '0, b_stall_cnt;

    regfile_scoreboard #(.NUM_REGS(6)) dut_b (
        .clk(clk), .rst(rst), .rd_en(b_rd_en), .rd_sel(b_rd_sel), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .iss_en(b_iss_en), .iss_sel(b_iss_sel), .iss_ack(b_iss_ack),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data), .stall(b_stall),
        .stall_cnt(b_stall_cnt), .err(b_err)
    );

    // Wide configuration with hardwired-zero r0
    logic [2:0]  c_rd_en = '0;
    logic [11:0] c_rd_sel = '0;
    logic [95:0] c_rd_data;
    logic [2:0]  c_rd_busy;
    logic        c_iss_en = 1'b0, c_iss_ack, c_wr_en = 1'b0, c_stall, c_err;
    logic [3:0]  c_iss_sel = '0, c_wr_sel = '0;
    logic [31:0] c_wr_data = '0;
    logic [15:0] c_stall_cnt;

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(16), .NUM_READ(3), .R0_ZERO(1)) dut_c (
        .clk(clk), .rst(rst), .rd_en(c_rd_en), .rd_sel(c_rd_sel), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .iss_en(c_iss_en), .iss_sel(c_iss_sel), .iss_ack(c_iss_ack),
        .wr_en(c_wr_en), .wr_sel(c_wr_sel), .wr_data(c_wr_data), .stall(c_stall),
        .stall_cnt(c_stall_cnt), .err(c_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  rd_en;
        logic [2:0]  s0, s1;
        logic        iss_en;
        logic [2:0]  iss_sel;
        logic        wr_en;
        logic [2:0]  wr_sel;
        logic [15:0] wr_data;
        logic [15:0] d0, d1;
        logic [1:0]  busy;
        logic        stall, ack, err;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic err_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        //             rd  s0 s1 ie is we ws wdata      d0        d1       busy st ak er
        vecs.push_back('{2'b00,0,0,0,0,0,0,16'h0000, 16'h0000,16'h0000,2'b00,0,0,0,"idle"});
        vecs.push_back('{2'b00,0,0,1,2,0,0,16'h0000, 16'h0000,16'h0000,2'b00,0,1,0,"issue_r2"});
        vecs.push_back('{2'b01,2,0,1,3,0,0,16'h0000, 16'h0000,16'h0000,2'b01,1,0,0,"raw_r2"});
        vecs.push_back('{2'b01,2,0,0,0,1,2,16'hBEEF, 16'hBEEF,16'h0000,2'b00,0,0,0,"bypass_r2"});
        vecs.push_back('{2'b11,2,2,0,0,0,0,16'h0000, 16'hBEEF,16'hBEEF,2'b00,0,0,0,"readback_r2"});
        vecs.push_back('{2'b00,0,0,1,5,0,0,16'h0000, 16'h0000,16'h0000,2'b00,0,1,0,"issue_r5"});
        vecs.push_back('{2'b00,0,0,1,5,0,0,16'h0000, 16'h0000,16'h0000,2'b00,1,0,0,"waw_r5"});
        vecs.push_back('{2'b00,0,5,1,5,1,5,16'h1111, 16'h0000,16'h1111,2'b00,0,1,0,"waw_wb_r5"});
        vecs.push_back('{2'b10,0,5,0,0,0,0,16'h0000, 16'h0000,16'h1111,2'b10,1,0,0,"r5_still_pending"});
        vecs.push_back('{2'b00,4,0,0,0,1,4,16'h0A0A, 16'h0A0A,16'h0000,2'b00,0,0,1,"wb_unpending_r4"});
        vecs.push_back('{2'b11,4,5,0,0,1,5,16'h2222, 16'h0A0A,16'h2222,2'b00,0,0,0,"wb_r5_bypass"});
        vecs.push_back('{2'b11,5,4,0,0,0,0,16'h0000, 16'h2222,16'h0A0A,2'b00,0,0,0,"r5_r4_array"});
        vecs.push_back('{2'b00,0,0,1,7,0,0,16'h0000, 16'h0000,16'h0000,2'b00,0,1,0,"issue_r7"});
        vecs.push_back('{2'b10,0,7,1,1,0,0,16'h0000, 16'h0000,16'h0000,2'b10,1,0,0,"raw_port1_r7"});
        vecs.push_back('{2'b01,7,6,0,0,1,6,16'h6666, 16'h0000,16'h6666,2'b01,1,0,1,"raw_other_wb"});

        // Reset state, with iss_en high to show iss_ack follows it
        a_iss_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall_cnt", a_stall_cnt, 16'h0);
        check("reset err", a_err, 1'b0);
        check("reset stall", a_stall, 1'b0);
        check("reset iss_ack", a_iss_ack, 1'b1);
        check("reset rd_busy", a_rd_busy, 2'b00);
        check("reset rd_data", a_rd_data, 32'h0);
        @(negedge clk);
        a_iss_en = 1'b0;
        rst = 1'b0;

        // Wide config: r0 hardwired, triple read of r15, issue to r0 never pends
        @(negedge clk);
        c_wr_en = 1'b1; c_wr_sel = 4'd0; c_wr_data = 32'hFFFF_0001;
        #1; check("c r0 bypass suppressed", c_rd_data, 96'h0);
        @(posedge clk); #1; check("c r0 write no err", c_err, 1'b0);
        @(negedge clk);
        c_wr_en = 1'b0; c_iss_en = 1'b1; c_iss_sel = 4'd15;
        #1; check("c r0 array reads 0", c_rd_data, 96'h0);
        check("c issue r15 ack", c_iss_ack, 1'b1);
        @(negedge clk);
        c_iss_en = 1'b0; c_wr_en = 1'b1; c_wr_sel = 4'd15; c_wr_data = 32'h1234_5678;
        @(posedge clk); #1; check("c wb r15 no err", c_err, 1'b0);
        @(negedge clk);
        c_wr_en = 1'b0; c_rd_en = 3'b111; c_rd_sel = {4'd15, 4'd15, 4'd15};
        #1; check("c triple read r15", c_rd_data, {3{32'h1234_5678}});
        check("c r15 not busy", c_rd_busy, 3'b000);
        @(negedge clk);
        c_rd_en = 3'b000; c_iss_en = 1'b1; c_iss_sel = 4'd0;
        #1; check("c issue r0 ack", c_iss_ack, 1'b1);
        @(negedge clk);
        c_rd_en = 3'b111; c_rd_sel = 12'h000;
        #1; check("c r0 never pending stall", c_stall, 1'b0);
        check("c r0 never pending busy", c_rd_busy, 3'b000);
        check("c reissue r0 ack", c_iss_ack, 1'b1);
        @(negedge clk);
        c_rd_en = 3'b000; c_iss_en = 1'b0;

        // Six-register config: out-of-range write/read/issue
        b_wr_en = 1'b1; b_wr_sel = 3'd2; b_wr_data = 16'h5555;
        @(posedge clk); #1; check("b wb unpending r2 err", b_err, 1'b1);
        @(negedge clk);
        b_wr_sel = 3'd7; b_wr_data = 16'hFFFF; b_rd_sel = {3'd2, 3'd7};
        #1; check("b oob read/no bypass", b_rd_data, {16'h5555, 16'h0000});
        @(posedge clk); #1; check("b oob write err", b_err, 1'b1);
        @(negedge clk);
        b_wr_en = 1'b0; b_rd_sel = {3'd0, 3'd2};
        #1; check("b r2 unchanged", b_rd_data[15:0], 16'h5555);
        @(posedge clk); #1; check("b err one cycle", b_err, 1'b0);
        @(negedge clk);
        b_rd_en = 2'b10; b_rd_sel = {3'd6, 3'd2};
        #1; check("b oob rd busy", b_rd_busy, 2'b00);
        @(posedge clk); #1; check("b oob rd err", b_err, 1'b1);
        @(negedge clk);
        b_rd_en = 2'b00; b_iss_en = 1'b1; b_iss_sel = 3'd7;
        #1; check("b oob issue ack", b_iss_ack, 1'b1);
        @(posedge clk); #1; check("b oob issue err", b_err, 1'b1);
        @(negedge clk);
        #1; check("b oob issue no pend", b_stall, 1'b0);
        @(negedge clk);
        b_iss_en = 1'b0;

        // Table-driven vectors on the default configuration
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_rd_en = vecs[i].rd_en;   a_rd_sel = {vecs[i].s1, vecs[i].s0};
            a_iss_en = vecs[i].iss_en; a_iss_sel = vecs[i].iss_sel;
            a_wr_en = vecs[i].wr_en;   a_wr_sel = vecs[i].wr_sel; a_wr_data = vecs[i].wr_data;
            #1;
            check($sformatf("%s rd_data0", vecs[i].name), a_rd_data[15:0], vecs[i].d0);
            check($sformatf("%s rd_data1", vecs[i].name), a_rd_data[31:16], vecs[i].d1);
            check($sformatf("%s rd_busy", vecs[i].name), a_rd_busy, vecs[i].busy);
            check($sformatf("%s stall", vecs[i].name), a_stall, vecs[i].stall);
            check($sformatf("%s iss_ack", vecs[i].name), a_iss_ack, vecs[i].ack);
            err_q.push_back(vecs[i].err);
            @(posedge clk); #1;
            check($sformatf("%s err", vecs[i].name), a_err, err_q.pop_front());
            $display("vector %0d %s applied", i, vecs[i].name);
        end
        check("stall_cnt after table", a_stall_cnt, 16'd5);

        // Saturation: r7 stays pending while port 0 reads it
        @(negedge clk);
        a_rd_en = 2'b01; a_rd_sel = {3'd0, 3'd7};
        a_iss_en = 1'b0; a_wr_en = 1'b0;
        repeat (65540) @(posedge clk);
        #1; check("stall_cnt saturated", a_stall_cnt, 16'hFFFF);
        check("stall held", a_stall, 1'b1);
        @(posedge clk); #1; check("stall_cnt no wrap", a_stall_cnt, 16'hFFFF);

        // Async reset mid-operation with r3 pending and holding 0x1234
        @(negedge clk);
        a_rd_en = 2'b00; a_iss_en = 1'b1; a_iss_sel = 3'd3;
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_sel = 3'd3; a_wr_data = 16'h1234;
        #1; check("wb+issue same reg ack", a_iss_ack, 1'b1);
        @(negedge clk);
        a_wr_en = 1'b0; a_iss_sel = 3'd0; a_rd_en = 2'b01; a_rd_sel = {3'd0, 3'd3};
        #1; check("pre-reset r3 data", a_rd_data[15:0], 16'h1234);
        check("pre-reset r3 still pending", a_rd_busy, 2'b01);
        check("pre-reset iss_ack stalled", a_iss_ack, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async reset rd_data0", a_rd_data[15:0], 16'h0);
        check("async reset rd_busy", a_rd_busy, 2'b00);
        check("async reset stall", a_stall, 1'b0);
        check("async reset iss_ack", a_iss_ack, 1'b1);
        check("async reset stall_cnt", a_stall_cnt, 16'h0);
        check("async reset err", a_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        a_iss_en = 1'b0; a_rd_en = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
